// File: rtl/pwm_ramp_ctrl_pkg.sv
// pwm_pkg: shared types and helpers for the PWM soft-start ramp controller.
//   ramp_state_e : controller states. STOP is encoded only when the
//                  PWM_SOFT_STOP_EN macro is defined.
//   *_DEF        : default parameter values for WIDTH / STEP_W / DIV_W.
//   sat_step()   : one clamped duty step toward a target.
package pwm_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int STEP_W_DEF = 4;
  localparam int DIV_W_DEF  = 8;

  // Working width for sat_step. It is wider than any supported duty width,
  // so cur+step can never wrap.
  localparam int SAT_W = 32;

`ifdef PWM_SOFT_STOP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } ramp_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } ramp_state_e;
`endif

  // Move cur toward tgt by at most step. The result never passes tgt.
  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] cur,
                                                input logic [SAT_W-1:0] tgt,
                                                input logic [SAT_W-1:0] step);
    logic [SAT_W-1:0] nxt;
    if (tgt > cur) begin
      nxt = cur + step;
      if (nxt > tgt) nxt = tgt;
    end else begin
      nxt = ((cur - tgt) > step) ? (cur - step) : tgt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: configuration channel into the ramp controller.
//   cfg_valid  : master offers a config
//   cfg_ready  : controller can accept (high in IDLE and HOLD)
//   cfg_target : target duty
//   cfg_step   : duty increment per step (0 behaves as 1)
//   cfg_div    : one step every cfg_div+1 PWM periods
// A transfer happens on any rising clk edge where cfg_valid && cfg_ready.
// The master holds the fields stable while cfg_valid is high. cfg_ready does
// not depend on cfg_valid.
interface pwm_ramp_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int DIV_W  = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WIDTH-1:0]  cfg_target;
  logic [STEP_W-1:0] cfg_step;
  logic [DIV_W-1:0]  cfg_div;

  modport master (output cfg_valid, output cfg_target, output cfg_step,
                  output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_target, input cfg_step,
                  input cfg_div, output cfg_ready);
endinterface

// File: rtl/pwm_ramp_ctrl_period_timer.sv
// pwm_period_timer: mirrors the PWM period counter and divides periods into
// duty-step ticks.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : PWM enable. The counter is held at 0 while it is low.
//   active     : divider counts only while this is high (RAMP/STOP)
//   dclr       : clears the divider (controller is changing state)
//   div        : one tick every div+1 periods
//   period_end : last cycle of the current PWM period
//   step_tick  : period_end on which the controller should step duty
module pwm_period_timer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             active,
  input  logic             dclr,
  input  logic [DIV_W-1:0] div,
  output logic             period_end,
  output logic             step_tick
);

  logic [WIDTH-1:0] pcnt;
  logic [DIV_W-1:0] dcnt;

  // Held at 0 while enable is low. The first enabled cycle therefore sees
  // pcnt==0, in step with the PWM's own counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pcnt <= '0;
    else if (!enable) pcnt <= '0;
    else              pcnt <= pcnt + 1'b1;
  end

  assign period_end = enable && (pcnt == '1);
  assign step_tick  = active && period_end && (dcnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   dcnt <= '0;
    else if (dclr || !enable)     dcnt <= '0;
    else if (active && period_end) begin
      if (dcnt == div) dcnt <= '0;
      else             dcnt <= dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start ramp controller in front of a PWM instance.
// Defining PWM_SOFT_STOP_EN enables the STOP state, which ramps the duty
// down to 0 when run falls. Without the macro, run falling stops the PWM
// at once.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : level request, high = PWM active
//   cfg        : config channel (see pwm_ramp_ctrl_if)
//   pwm_enable : to PWM enable
//   pwm_duty   : to PWM duty (registered)
//   period_end : pulse on the last cycle of each PWM period
//   busy       : high in RAMP/STOP
//   at_target  : high in HOLD
//   state      : current FSM state (debug)
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  pwm_ramp_ctrl_if.slave    cfg,
  output logic              pwm_enable,
  output logic [WIDTH-1:0]  pwm_duty,
  output logic              period_end,
  output logic              busy,
  output logic              at_target,
  output ramp_state_e       state
);

  ramp_state_e       state_q, state_d;
  logic [WIDTH-1:0]  duty_q, duty_d;
  logic [WIDTH-1:0]  target_q;
  logic [STEP_W-1:0] step_q;
  logic [DIV_W-1:0]  div_q;

  logic              cfg_fire;
  logic              step_tick;
  logic              active;
  logic [STEP_W-1:0] step_eff;
  logic [WIDTH-1:0]  eff_target;
  logic [WIDTH-1:0]  up_next;

  assign cfg.cfg_ready = (state_q == IDLE) || (state_q == HOLD);
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;

  assign pwm_enable = (state_q != IDLE);
  assign pwm_duty   = duty_q;
  assign at_target  = (state_q == HOLD);
  assign state      = state_q;

`ifdef PWM_SOFT_STOP_EN
  logic [WIDTH-1:0] down_next;
  assign active    = (state_q == RAMP) || (state_q == STOP);
  assign down_next = WIDTH'(sat_step(SAT_W'(duty_q), '0, SAT_W'(step_eff)));
`else
  assign active    = (state_q == RAMP);
`endif
  assign busy = active;

  assign step_eff = (step_q == '0) ? STEP_W'(1) : step_q;
  assign up_next  = WIDTH'(sat_step(SAT_W'(duty_q), SAT_W'(target_q),
                                    SAT_W'(step_eff)));

  // A run request in IDLE that arrives with a config uses the incoming target.
  assign eff_target = cfg_fire ? cfg.cfg_target : target_q;

  pwm_period_timer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (pwm_enable),
    .active     (active),
    .dclr       (state_d != state_q),
    .div        (div_q),
    .period_end (period_end),
    .step_tick  (step_tick)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    case (state_q)
      IDLE: begin
        duty_d = '0;
        if (run) state_d = (eff_target == '0) ? HOLD : RAMP;
      end
      RAMP: begin
        if (!run) begin
`ifdef PWM_SOFT_STOP_EN
          state_d = STOP;
`else
          state_d = IDLE;
          duty_d  = '0;
`endif
        end else if (step_tick) begin
          duty_d = up_next;
          // The final step and the move to HOLD happen on the same edge.
          if (up_next == target_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (!run) begin
`ifdef PWM_SOFT_STOP_EN
          state_d = STOP;
`else
          state_d = IDLE;
          duty_d  = '0;
`endif
        end else if (cfg_fire && (cfg.cfg_target != duty_q)) begin
          state_d = RAMP;
        end
      end
`ifdef PWM_SOFT_STOP_EN
      STOP: begin
        if (run)                             state_d = RAMP;
        else if (period_end && duty_q == '0) state_d = IDLE;
        else if (step_tick)                  duty_d  = down_next;
      end
`endif
      default: begin
        state_d = IDLE;
        duty_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  // The config is latched even when a stop wins on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      step_q   <= '0;
      div_q    <= '0;
    end else if (cfg_fire) begin
      target_q <= cfg.cfg_target;
      step_q   <= cfg.cfg_step;
      div_q    <= cfg.cfg_div;
    end
  end

endmodule
